hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the stall and flush controls for fetch, decode, execute and memory:
  - one-cycle load-use bubbles,
  - delayed JAL squash,
  - taken-branch/JALR squash,
  - multicycle data-memory wait freeze.
- Sits beside the stages; decode's stall, jal_flush and branch_flush inputs are driven directly by this block.
- Also keeps stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: the pipeline-side hazard inputs and the
// stall/flush/status outputs of hazard_ctrl.
// The pipeline (master) drives the hazard inputs; the controller (slave)
// drives the stall/flush controls, the error flag and the counters.

interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_jal;
  logic             ex_load;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             fetch_stall;
  logic             fetch_flush;
  logic             stall;
  logic             jal_flush;
  logic             branch_flush;
  logic             ex_stall;
  logic             mem_stall;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_jal, ex_load, ex_rd, ex_redirect,
           mem_req, mem_ready,
    input  fetch_stall, fetch_flush, stall, jal_flush, branch_flush,
           ex_stall, mem_stall, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_jal, ex_load, ex_rd, ex_redirect,
           mem_req, mem_ready,
    output fetch_stall, fetch_flush, stall, jal_flush, branch_flush,
           ex_stall, mem_stall, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Produces load-use bubbles, delayed JAL squash, taken-branch/JALR squash
// and a full-pipeline freeze while data memory is waiting. Stall/flush
// controls are combinational; error flag and counters are registered.

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hc
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        state_r;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic              jal_pend_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic freeze_s;
  logic timeout_s;
  logic load_use_raw_s;
  logic redirect_s;
  logic load_use_s;
  logic jal_squash_s;
  logic fetch_stall_s;
  logic any_flush_s;

  // Memory-wait freeze and timeout detection (forced inactive during reset)
  always_comb begin
    freeze_s  = 1'b0;
    timeout_s = 1'b0;
    if (!rst) begin
      freeze_s  = 1'b0;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          freeze_s = hc.mem_req & ~hc.mem_ready;
        end
        MEM_WAIT: begin
          if (hc.mem_ready) begin
            freeze_s = 1'b0;
          end else if (wait_cnt_r == WCNT_W'(MEM_TIMEOUT)) begin
            timeout_s = 1'b1;
          end else begin
            freeze_s = 1'b1;
          end
        end
        default: begin
          freeze_s  = 1'b0;
          timeout_s = 1'b0;
        end
      endcase
    end
  end

  // Hazard priority: freeze masks everything, then redirect, load-use, JAL
  always_comb begin
    // x0 is never a real producer, so it cannot create a load-use hazard
    load_use_raw_s = hc.ex_load & (hc.ex_rd != 5'd0) &
                     ((hc.ex_rd == hc.id_rs1) | (hc.ex_rd == hc.id_rs2));
    if (rst && !freeze_s) begin
      redirect_s   = hc.ex_redirect;
      load_use_s   = ~hc.ex_redirect & load_use_raw_s;
      jal_squash_s = ~hc.ex_redirect & ~load_use_raw_s & jal_pend_r;
    end else begin
      redirect_s   = 1'b0;
      load_use_s   = 1'b0;
      jal_squash_s = 1'b0;
    end
    fetch_stall_s = freeze_s | load_use_s;
    any_flush_s   = redirect_s | load_use_s | jal_squash_s;
  end

  assign hc.fetch_stall  = fetch_stall_s;
  assign hc.fetch_flush  = redirect_s;
  assign hc.stall        = freeze_s;
  assign hc.jal_flush    = jal_squash_s;
  // Load-use reuses decode's branch_flush to inject the bubble into execute
  assign hc.branch_flush = redirect_s | load_use_s;
  assign hc.ex_stall     = freeze_s;
  assign hc.mem_stall    = freeze_s;
  assign hc.mem_err      = mem_err_r;
  assign hc.stall_cnt    = stall_cnt_r;
  assign hc.flush_cnt    = flush_cnt_r;

  // Memory-wait state and consecutive wait-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RUN;
      wait_cnt_r <= WCNT_W'(0);
    end else if (freeze_s) begin
      state_r    <= MEM_WAIT;
      wait_cnt_r <= (state_r == RUN) ? WCNT_W'(1) : wait_cnt_r + WCNT_W'(1);
    end else begin
      state_r    <= RUN;
      wait_cnt_r <= WCNT_W'(0);
    end
  end

  // Pending JAL: set when a JAL really advances out of decode input;
  // held across freezes and load-use stalls, dropped on redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jal_pend_r <= 1'b0;
    end else if (freeze_s || load_use_s) begin
      jal_pend_r <= jal_pend_r;
    end else if (redirect_s) begin
      jal_pend_r <= 1'b0;
    end else begin
      jal_pend_r <= hc.id_jal;
    end
  end

  // Sticky memory timeout error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err_r <= 1'b0;
    end else if (timeout_s) begin
      mem_err_r <= 1'b1;
    end else begin
      mem_err_r <= mem_err_r;
    end
  end

  // Wrapping stall/flush performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(fetch_stall_s);
      flush_cnt_r <= flush_cnt_r + CNT_W'(any_flush_s);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.

module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hc ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hc  (hc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_waiting;
  int m_wait_cycles;
  bit m_pend;
  bit m_err;
  int m_scnt;
  int m_fcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_flags();
    return {hc.fetch_stall, hc.fetch_flush, hc.stall, hc.jal_flush,
            hc.branch_flush, hc.ex_stall, hc.mem_stall};
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_wait_cycles = 0; m_pend = 0;
    m_err = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic jal,
                      input logic ld, input logic [4:0] rd, input logic redir,
                      input logic req, input logic rdy);
    bit frozen, timed_out, hazard, lu, br, jf, fs;
    logic [6:0] exp_flags;
    @(negedge clk);
    hc.id_rs1 = rs1; hc.id_rs2 = rs2; hc.id_jal = jal;
    hc.ex_load = ld; hc.ex_rd = rd; hc.ex_redirect = redir;
    hc.mem_req = req; hc.mem_ready = rdy;
    #1;
    // A memory op that has not completed freezes the pipe, unless it has
    // already waited MEM_TIMEOUT cycles, in which case it is abandoned.
    if (m_waiting) begin
      frozen    = !rdy && (m_wait_cycles < MEM_TIMEOUT);
      timed_out = !rdy && (m_wait_cycles >= MEM_TIMEOUT);
    end else begin
      frozen    = req && !rdy;
      timed_out = 0;
    end
    hazard = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    br = 0; lu = 0; jf = 0;
    if (!frozen) begin
      if (redir)       br = 1;
      else if (hazard) lu = 1;
      else if (m_pend) jf = 1;
    end
    fs = frozen || lu;
    exp_flags = {fs, br, frozen, jf, br || lu, frozen, frozen};
    check_val("flags", {25'd0, dut_flags()}, {25'd0, exp_flags});
    check_val("stall_cnt", 32'(hc.stall_cnt), 32'(m_scnt));
    check_val("flush_cnt", 32'(hc.flush_cnt), 32'(m_fcnt));
    check_val("mem_err", {31'd0, hc.mem_err}, {31'd0, m_err});
    if (hc.stall && (hc.jal_flush || hc.branch_flush))
      check_val("stall_vs_flush", 32'd1, 32'd0);
    if (hc.jal_flush && hc.branch_flush)
      check_val("jal_vs_branch", 32'd1, 32'd0);
    // advance model to the post-edge state
    if (frozen) begin
      m_wait_cycles = m_waiting ? m_wait_cycles + 1 : 1;
      m_waiting = 1;
    end else begin
      m_waiting = 0; m_wait_cycles = 0;
    end
    if (timed_out) m_err = 1;
    if (!frozen && !lu) m_pend = redir ? 1'b0 : jal;
    if (fs) m_scnt = (m_scnt + 1) % CNT_MOD;
    if (br || lu || jf) m_fcnt = (m_fcnt + 1) % CNT_MOD;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Assert reset with current inputs still applied; outputs must drop at once
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_flags", {25'd0, dut_flags()}, 32'd0);
    check_val("rst_stall_cnt", 32'(hc.stall_cnt), 32'd0);
    check_val("rst_flush_cnt", 32'(hc.flush_cnt), 32'd0);
    check_val("rst_mem_err", {31'd0, hc.mem_err}, 32'd0);
    model_reset();
    @(negedge clk);
    hc.mem_req = 1'b0; hc.mem_ready = 1'b1; hc.ex_load = 1'b0;
    hc.ex_redirect = 1'b0; hc.id_jal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    hc.id_rs1 = 5'd0; hc.id_rs2 = 5'd0; hc.id_jal = 1'b0;
    hc.ex_load = 1'b0; hc.ex_rd = 5'd0; hc.ex_redirect = 1'b0;
    hc.mem_req = 1'b0; hc.mem_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Load-use bubble, then x0 never hazards
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle();
    check_val("lu_stall_cnt", 32'(hc.stall_cnt), 32'd1);
    check_val("lu_flush_cnt", 32'(hc.flush_cnt), 32'd1);
    step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    check_val("x0_no_stall", {31'd0, hc.fetch_stall}, 32'd0);

    // JAL squash one cycle later; then JAL followed by redirect
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    idle();
    check_val("jal_flush_n1", {31'd0, hc.jal_flush}, 32'd1);
    idle();
    check_val("jal_flush_n2", {31'd0, hc.jal_flush}, 32'd0);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    check_val("jal_redir", {29'd0, hc.branch_flush, hc.fetch_flush, hc.jal_flush}, 32'b110);

    // JAL held by a load-use stall, then a 3-cycle memory wait with
    // redirect/load-use masked; the pending JAL survives the freeze
    step(5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    step(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
    check_val("wait_mem_stall", {31'd0, hc.mem_stall}, 32'd1);
    idle();
    check_val("wait_release", {31'd0, hc.ex_stall}, 32'd0);

    // Timeout: four stall cycles, released on the fifth, error sticky
    for (int i = 0; i < 5; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_val("to_released", {31'd0, hc.stall}, 32'd0);
    idle();
    check_val("to_mem_err", {31'd0, hc.mem_err}, 32'd1);
    idle();
    check_val("to_sticky", {31'd0, hc.mem_err}, 32'd1);

    // Counter wrap: 17 stall cycles after reset
    do_reset();
    for (int i = 0; i < 17; i++) step(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    idle();
    check_val("wrap_stall_cnt", 32'(hc.stall_cnt), 32'd1);

    // Reset in the middle of a memory wait
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle();
    check_val("post_rst_stall", {31'd0, hc.stall}, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
